dbg_ahb_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared debug AHB-lite master port. Requester 0 is the UART debug bridge and requester 1 is the DMA/CPU-side debug agent. Each requester issues single-beat transfers over a simple req/ack handshake. The block serialises them with round-robin or fixed priority and drives one AHB-lite single transfer per grant, with an error/timeout return path.

---
 rtl/dbg_ahb_pkg.sv | 33 +++
 rtl/dbg_ahb_timeout.sv | 35 +++
 rtl/dbg_ahb_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_dbg_ahb_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_ahb_pkg.sv
// Shared encodings for the debug AHB-lite arbiter: FSM states, AHB codes and
// the two-requester winner selection.
package dbg_ahb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10,
      ST_RESP = 2'b11
   } state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   // Returns the winning requester index; on a round-robin tie the requester
   // that did not own the last grant wins.
   function automatic logic pick_winner(input logic req0,
                                        input logic req1,
                                        input logic owner,
                                        input logic fixed_prio);
      if (req0 && req1) begin
         return fixed_prio ? 1'b0 : ~owner;
      end
      return req1 && !req0;
   endfunction

endpackage

// File: rtl/dbg_ahb_timeout.sv
// Wait-state watchdog: counts stalled ADDR/DATA cycles since the last grant and
// flags expiry once the count reaches TIMEOUT_CYCLES (saturates there).
module dbg_ahb_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired_o = (cnt_q == CW'(TIMEOUT_CYCLES));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dbg_ahb_arbiter.sv
// Two-requester arbiter driving one registered AHB-lite single transfer per grant,
// with per-requester ack/rdata/err return and a wait-state timeout abort.
module dbg_ahb_arbiter
   import dbg_ahb_pkg::*;
#(
   parameter bit          FIXED_PRIO     = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_req_i,
   input  logic        m0_write_i,
   input  logic [31:0] m0_addr_i,
   input  logic [2:0]  m0_size_i,
   input  logic [31:0] m0_wdata_i,
   input  logic [3:0]  m0_wstrb_i,
   output logic        m0_ack_o,
   output logic [31:0] m0_rdata_o,
   output logic        m0_err_o,
   input  logic        m1_req_i,
   input  logic        m1_write_i,
   input  logic [31:0] m1_addr_i,
   input  logic [2:0]  m1_size_i,
   input  logic [31:0] m1_wdata_i,
   input  logic [3:0]  m1_wstrb_i,
   output logic        m1_ack_o,
   output logic [31:0] m1_rdata_o,
   output logic        m1_err_o,
   output logic        hsel_o,
   output logic        hwrite_o,
   output logic [31:0] haddr_o,
   output logic [2:0]  hsize_o,
   output logic [2:0]  hburst_o,
   output logic [1:0]  htrans_o,
   output logic [31:0] hwdata_o,
   output logic [3:0]  hwuser_o,
   input  logic        hready_i,
   input  logic [31:0] hrdata_i,
   input  logic        hresp_i,
   output logic        owner_o
);

   state_e            state_q, state_d;
   logic              hsel_q, hsel_d;
   logic              hwrite_q, hwrite_d;
   logic [31:0]       haddr_q, haddr_d;
   logic [2:0]        hsize_q, hsize_d;
   logic [1:0]        htrans_q, htrans_d;
   logic [31:0]       hwdata_q, hwdata_d;
   logic [3:0]        hwuser_q, hwuser_d;
   logic              owner_q, owner_d;
   logic [1:0]        ack_q, ack_d;
   logic [1:0]        err_q, err_d;
   logic [1:0][31:0]  rdata_q, rdata_d;

   logic              win;
   logic              resp_vld;
   logic [31:0]       resp_dat;
   logic              resp_err;
   logic              tmo_clr, tmo_en, tmo_expired;

   dbg_ahb_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (tmo_clr),
      .en_i     (tmo_en),
      .expired_o(tmo_expired)
   );

   assign win = pick_winner(m0_req_i, m1_req_i, owner_q, FIXED_PRIO);

   always_comb begin
      state_d  = state_q;
      hsel_d   = hsel_q;
      hwrite_d = hwrite_q;
      haddr_d  = haddr_q;
      hsize_d  = hsize_q;
      htrans_d = htrans_q;
      hwdata_d = hwdata_q;
      hwuser_d = hwuser_q;
      owner_d  = owner_q;
      ack_d    = '0;
      err_d    = err_q;
      rdata_d  = rdata_q;
      resp_vld = 1'b0;
      resp_dat = '0;
      resp_err = 1'b0;
      tmo_clr  = 1'b0;
      tmo_en   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (m0_req_i || m1_req_i) begin
               owner_d  = win;
               hwrite_d = win ? m1_write_i : m0_write_i;
               haddr_d  = win ? m1_addr_i  : m0_addr_i;
               hsize_d  = win ? m1_size_i  : m0_size_i;
               hwdata_d = win ? m1_wdata_i : m0_wdata_i;
               hwuser_d = win ? m1_wstrb_i : m0_wstrb_i;
               hsel_d   = 1'b1;
               htrans_d = HTRANS_NONSEQ;
               tmo_clr  = 1'b1;
               state_d  = ST_ADDR;
            end
         end
         ST_ADDR, ST_DATA: begin
            // Expiry wins over a late hready so the abort lands on a fixed cycle.
            if (tmo_expired) begin
               hsel_d   = 1'b0;
               htrans_d = HTRANS_IDLE;
               resp_vld = 1'b1;
               resp_err = 1'b1;
               state_d  = ST_RESP;
            end else if (hready_i) begin
               if (state_q == ST_ADDR) begin
                  hsel_d   = 1'b0;
                  htrans_d = HTRANS_IDLE;
                  state_d  = ST_DATA;
               end else begin
                  resp_vld = 1'b1;
                  resp_dat = hwrite_q ? 32'h0 : hrdata_i;
                  resp_err = hresp_i;
                  state_d  = ST_RESP;
               end
            end else begin
               tmo_en = 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (resp_vld) begin
         ack_d[owner_q]   = 1'b1;
         rdata_d[owner_q] = resp_dat;
         err_d[owner_q]   = resp_err;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= ST_IDLE;
         hsel_q   <= 1'b0;
         hwrite_q <= 1'b0;
         haddr_q  <= '0;
         hsize_q  <= '0;
         htrans_q <= HTRANS_IDLE;
         hwdata_q <= '0;
         hwuser_q <= '0;
         owner_q  <= 1'b0;
         ack_q    <= '0;
         err_q    <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         hsel_q   <= hsel_d;
         hwrite_q <= hwrite_d;
         haddr_q  <= haddr_d;
         hsize_q  <= hsize_d;
         htrans_q <= htrans_d;
         hwdata_q <= hwdata_d;
         hwuser_q <= hwuser_d;
         owner_q  <= owner_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   assign hsel_o     = hsel_q;
   assign hwrite_o   = hwrite_q;
   assign haddr_o    = haddr_q;
   assign hsize_o    = hsize_q;
   assign hburst_o   = HBURST_SINGLE;
   assign htrans_o   = htrans_q;
   assign hwdata_o   = hwdata_q;
   assign hwuser_o   = hwuser_q;
   assign owner_o    = owner_q;
   assign m0_ack_o   = ack_q[0];
   assign m1_ack_o   = ack_q[1];
   assign m0_err_o   = err_q[0];
   assign m1_err_o   = err_q[1];
   assign m0_rdata_o = rdata_q[0];
   assign m1_rdata_o = rdata_q[1];

endmodule

// File: tb/tb_dbg_ahb_arbiter.sv
// Directed bench for dbg_ahb_arbiter: a round-robin instance and a fixed-priority
// instance share all inputs; both use an 8-cycle timeout.
module tb_dbg_ahb_arbiter;
   import dbg_ahb_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        m0_req_i, m0_write_i, m1_req_i, m1_write_i;
   logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
   logic [2:0]  m0_size_i, m1_size_i;
   logic [3:0]  m0_wstrb_i, m1_wstrb_i;
   logic        hready_i, hresp_i;
   logic [31:0] hrdata_i;

   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        hsel_o, hwrite_o, owner_o;
   logic [31:0] haddr_o, hwdata_o;
   logic [2:0]  hsize_o, hburst_o;
   logic [1:0]  htrans_o;
   logic [3:0]  hwuser_o;

   logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
   logic [31:0] b_m0_rdata, b_m1_rdata;
   logic        b_hsel, b_hwrite, b_owner;
   logic [31:0] b_haddr, b_hwdata;
   logic [2:0]  b_hsize, b_hburst;
   logic [1:0]  b_htrans;
   logic [3:0]  b_hwuser;

   int vecs = 0;
   int errs = 0;

   always #5 clk_i = ~clk_i;

   dbg_ahb_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT_CYCLES(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_req_i(m0_req_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
      .m0_size_i(m0_size_i), .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i),
      .m0_ack_o(m0_ack_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
      .m1_req_i(m1_req_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
      .m1_size_i(m1_size_i), .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i),
      .m1_ack_o(m1_ack_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
      .hsel_o(hsel_o), .hwrite_o(hwrite_o), .haddr_o(haddr_o), .hsize_o(hsize_o),
      .hburst_o(hburst_o), .htrans_o(htrans_o), .hwdata_o(hwdata_o), .hwuser_o(hwuser_o),
      .hready_i(hready_i), .hrdata_i(hrdata_i), .hresp_i(hresp_i), .owner_o(owner_o)
   );

   dbg_ahb_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT_CYCLES(8)) dut_fixed (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_req_i(m0_req_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
      .m0_size_i(m0_size_i), .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i),
      .m0_ack_o(b_m0_ack), .m0_rdata_o(b_m0_rdata), .m0_err_o(b_m0_err),
      .m1_req_i(m1_req_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
      .m1_size_i(m1_size_i), .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i),
      .m1_ack_o(b_m1_ack), .m1_rdata_o(b_m1_rdata), .m1_err_o(b_m1_err),
      .hsel_o(b_hsel), .hwrite_o(b_hwrite), .haddr_o(b_haddr), .hsize_o(b_hsize),
      .hburst_o(b_hburst), .htrans_o(b_htrans), .hwdata_o(b_hwdata), .hwuser_o(b_hwuser),
      .hready_i(hready_i), .hrdata_i(hrdata_i), .hresp_i(hresp_i), .owner_o(b_owner)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [1:0] rr_order [4];
      rr_order = '{2'd0, 2'd1, 2'd0, 2'd1};

      rst_i = 1'b0;
      m0_req_i = 0; m0_write_i = 0; m0_addr_i = '0; m0_size_i = '0; m0_wdata_i = '0; m0_wstrb_i = '0;
      m1_req_i = 0; m1_write_i = 0; m1_addr_i = '0; m1_size_i = '0; m1_wdata_i = '0; m1_wstrb_i = '0;
      hready_i = 1'b1; hresp_i = 1'b0; hrdata_i = '0;
      tick(); tick();

      // Reset state
      chk("rst_hsel",   hsel_o,   0);
      chk("rst_htrans", htrans_o, 0);
      chk("rst_haddr",  haddr_o,  0);
      chk("rst_hwdata", hwdata_o, 0);
      chk("rst_hwuser", hwuser_o, 0);
      chk("rst_hburst", hburst_o, 0);
      chk("rst_owner",  owner_o,  0);
      chk("rst_acks",   {m0_ack_o, m1_ack_o}, 0);
      rst_i = 1'b1;
      tick();

      // Single read, zero wait states
      m0_req_i = 1; m0_write_i = 0; m0_addr_i = 32'h2000_0010; m0_size_i = HSIZE_WORD;
      hrdata_i = 32'hCAFE_0000;
      tick();
      chk("rd_c1_htrans", htrans_o, 2'b10);
      chk("rd_c1_hsel",   hsel_o,   1);
      chk("rd_c1_haddr",  haddr_o,  32'h2000_0010);
      chk("rd_c1_hsize",  hsize_o,  HSIZE_WORD);
      tick();
      chk("rd_c2_htrans", htrans_o, 2'b00);
      chk("rd_c2_ack",    m0_ack_o, 0);
      tick();
      chk("rd_c3_ack",    m0_ack_o,   1);
      chk("rd_c3_rdata",  m0_rdata_o, 32'hCAFE_0000);
      chk("rd_c3_err",    m0_err_o,   0);
      chk("rd_c3_m1ack",  m1_ack_o,   0);
      m0_req_i = 0;
      tick();
      chk("rd_c4_ack",    m0_ack_o, 0);
      chk("rd_c4_htrans", htrans_o, 2'b00);

      // Write with strobes from m1; hrdata is nonzero but a write returns 0
      m1_req_i = 1; m1_write_i = 1; m1_addr_i = 32'h2000_0004; m1_size_i = HSIZE_WORD;
      m1_wdata_i = 32'h1122_3344; m1_wstrb_i = 4'b0011;
      tick();
      chk("wr_c1_haddr",  haddr_o,  32'h2000_0004);
      chk("wr_c1_hwrite", hwrite_o, 1);
      chk("wr_c1_hwuser", hwuser_o, 4'b0011);
      chk("wr_c1_owner",  owner_o,  1);
      tick();
      chk("wr_c2_hwdata", hwdata_o, 32'h1122_3344);
      chk("wr_c2_hwuser", hwuser_o, 4'b0011);
      tick();
      chk("wr_c3_ack",    m1_ack_o,   1);
      chk("wr_c3_rdata",  m1_rdata_o, 0);
      chk("wr_c3_m0ack",  m0_ack_o,   0);
      m1_req_i = 0; m1_write_i = 0;
      tick();

      // Contention: both request continuously; round-robin alternates from last owner m1
      m0_req_i = 1; m0_addr_i = 32'h2000_0100;
      m1_req_i = 1; m1_addr_i = 32'h2000_0200;
      for (int g = 0; g < 4; g++) begin
         tick();
         chk($sformatf("rr_grant%0d_owner", g), owner_o, rr_order[g]);
         chk($sformatf("fp_grant%0d_owner", g), b_owner, 0);
         chk($sformatf("rr_grant%0d_haddr", g), haddr_o,
             (rr_order[g] == 2'd0) ? 32'h2000_0100 : 32'h2000_0200);
         tick(); tick();
         chk($sformatf("rr_grant%0d_ack", g), {m1_ack_o, m0_ack_o},
             (rr_order[g] == 2'd0) ? 2'b01 : 2'b10);
         if (g == 3) begin
            m0_req_i = 0; m1_req_i = 0;
         end
         tick();
      end

      // Three DATA wait states then an error response: ack in cycle 6
      m0_req_i = 1; m0_addr_i = 32'h2000_0020;
      tick();
      chk("ws_c1_htrans", htrans_o, 2'b10);
      tick();
      hready_i = 0;
      tick();
      chk("ws_c3_ack", m0_ack_o, 0);
      tick();
      tick();
      chk("ws_c5_ack", m0_ack_o, 0);
      hready_i = 1; hresp_i = 1; hrdata_i = 32'h1234_5678;
      tick();
      chk("ws_c6_ack",   m0_ack_o,   1);
      chk("ws_c6_err",   m0_err_o,   1);
      chk("ws_c6_rdata", m0_rdata_o, 32'h1234_5678);
      m0_req_i = 0; hresp_i = 0;
      tick();

      // Timeout with hready stuck low: abort ack 9 cycles after ADDR entry
      m1_req_i = 1; m1_addr_i = 32'h2000_0040; hready_i = 0; hrdata_i = 32'hFFFF_0000;
      tick();
      chk("to_c1_htrans", htrans_o, 2'b10);
      for (int c = 2; c <= 9; c++) tick();
      chk("to_c9_htrans", htrans_o, 2'b10);
      chk("to_c9_ack",    m1_ack_o, 0);
      tick();
      chk("to_c10_htrans", htrans_o,   2'b00);
      chk("to_c10_hsel",   hsel_o,     0);
      chk("to_c10_ack",    m1_ack_o,   1);
      chk("to_c10_err",    m1_err_o,   1);
      chk("to_c10_rdata",  m1_rdata_o, 0);
      m1_req_i = 0; hready_i = 1;
      tick();

      // Normal transfer after the timeout
      m0_req_i = 1; m0_addr_i = 32'h2000_0030; hrdata_i = 32'hA5A5_A5A5;
      tick(); tick(); tick();
      chk("post_to_ack",   m0_ack_o,   1);
      chk("post_to_rdata", m0_rdata_o, 32'hA5A5_A5A5);
      chk("post_to_err",   m0_err_o,   0);
      m0_req_i = 0;
      tick();

      // Reset asserted during DATA
      m0_req_i = 1; m0_write_i = 1; m0_addr_i = 32'h2000_0050; m0_wdata_i = 32'hDEAD_BEEF;
      m0_wstrb_i = 4'b1111;
      tick();
      tick();
      hready_i = 0;
      chk("rm_c2_hwdata", hwdata_o, 32'hDEAD_BEEF);
      #1 rst_i = 1'b0;
      #1;
      chk("rm_hwdata", hwdata_o, 0);
      chk("rm_haddr",  haddr_o,  0);
      chk("rm_hwrite", hwrite_o, 0);
      chk("rm_hwuser", hwuser_o, 0);
      chk("rm_owner",  owner_o,  0);
      m0_req_i = 0; m0_write_i = 0; hready_i = 1;
      tick(); tick();
      chk("rm_noack", {m0_ack_o, m1_ack_o}, 0);
      rst_i = 1'b1;
      tick();
      chk("rm_rel_noack", {m0_ack_o, m1_ack_o}, 0);

      m1_req_i = 1; m1_write_i = 0; m1_addr_i = 32'h2000_0060; hrdata_i = 32'h0BAD_F00D;
      tick();
      chk("rr_c1_htrans", htrans_o, 2'b10);
      tick(); tick();
      chk("rr_c3_ack",   m1_ack_o,   1);
      chk("rr_c3_rdata", m1_rdata_o, 32'h0BAD_F00D);
      m1_req_i = 0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
